// File: rtl/verlet_scheduler.sv
// Frame-level sequencer for the cloth/rope Node array.
// Each frame strobes every node once through its Verlet step, then runs
// CONSTRAINT_ITERS passes of the fix-constraint step, then pulses frame_done.
// A node that does not acknowledge within TIMEOUT cycles is skipped and logged.
module verlet_scheduler #(
    parameter int NODES            = 5,
    parameter int CONSTRAINT_ITERS = 3,
    parameter int TIMEOUT          = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NODES-1:0]         node_done,
    output logic [NODES-1:0]         verlet_state,
    output logic [NODES-1:0]         fix_state,
    output logic                     busy,
    output logic                     frame_done,
    output logic [31:0]              frame_count,
    output logic                     err,
    output logic [$clog2(NODES)-1:0] err_node
);

    localparam int IW = $clog2(NODES);
    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = (CONSTRAINT_ITERS > 1) ? $clog2(CONSTRAINT_ITERS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VERLET = 2'd1;
    localparam logic [1:0] ST_FIX    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [IW-1:0]    LAST_IDX     = IW'(NODES - 1);
    localparam logic [CW-1:0]    LAST_ITER    = CW'(CONSTRAINT_ITERS - 1);
    localparam logic [TW-1:0]    LAST_WAIT    = TW'(TIMEOUT - 1);
    localparam logic [NODES-1:0] FIRST_STROBE = {{(NODES-1){1'b0}}, 1'b1};
    localparam logic [NODES-1:0] NO_STROBE    = {NODES{1'b0}};

    logic [1:0]       state_r, state_s;
    logic [IW-1:0]    idx_r, idx_s;
    logic [CW-1:0]    iter_r, iter_s;
    logic [TW-1:0]    wait_r, wait_s;
    logic [NODES-1:0] verlet_s, fix_s;
    logic             busy_s, done_s, err_s;
    logic [31:0]      count_s;
    logic [IW-1:0]    err_node_s;
    logic             hit_s, tout_s, adv_s;

    // Next-state and next-output computation; every output is a register fed from here.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        iter_s     = iter_r;
        wait_s     = wait_r;
        verlet_s   = NO_STROBE;
        fix_s      = NO_STROBE;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        count_s    = frame_count;
        err_s      = err;
        err_node_s = err_node;
        // Only the strobed node's ack counts; an ack wins over a same-edge timeout.
        hit_s      = node_done[idx_r];
        tout_s     = (wait_r == LAST_WAIT);
        adv_s      = hit_s | tout_s;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_VERLET;
                    idx_s    = {IW{1'b0}};
                    wait_s   = {TW{1'b0}};
                    verlet_s = FIRST_STROBE;
                    busy_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_VERLET, ST_FIX: begin
                busy_s = 1'b1;
                if (adv_s) begin
                    wait_s = {TW{1'b0}};
                    if (!hit_s) begin
                        err_s      = 1'b1;
                        err_node_s = idx_r;
                    end else begin
                        err_s      = err;
                    end
                    if (idx_r == LAST_IDX) begin
                        idx_s = {IW{1'b0}};
                        if (state_r == ST_VERLET) begin
                            state_s = ST_FIX;
                            iter_s  = {CW{1'b0}};
                            fix_s   = FIRST_STROBE;
                        end else if (iter_r != LAST_ITER) begin
                            iter_s  = iter_r + CW'(1);
                            fix_s   = FIRST_STROBE;
                        end else begin
                            // The DONE cycle carries the pulse and the updated count.
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                            count_s = frame_count + 32'd1;
                        end
                    end else begin
                        idx_s = idx_r + IW'(1);
                        if (state_r == ST_VERLET) begin
                            verlet_s = FIRST_STROBE << idx_s;
                        end else begin
                            fix_s    = FIRST_STROBE << idx_s;
                        end
                    end
                end else begin
                    wait_s = wait_r + TW'(1);
                    if (state_r == ST_VERLET) begin
                        verlet_s = FIRST_STROBE << idx_r;
                    end else begin
                        fix_s    = FIRST_STROBE << idx_r;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {IW{1'b0}};
                iter_s  = {CW{1'b0}};
                wait_s  = {TW{1'b0}};
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IW{1'b0}};
            iter_r       <= {CW{1'b0}};
            wait_r       <= {TW{1'b0}};
            verlet_state <= NO_STROBE;
            fix_state    <= NO_STROBE;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= 32'd0;
            err          <= 1'b0;
            err_node     <= {IW{1'b0}};
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            iter_r       <= iter_s;
            wait_r       <= wait_s;
            verlet_state <= verlet_s;
            fix_state    <= fix_s;
            busy         <= busy_s;
            frame_done   <= done_s;
            frame_count  <= count_s;
            err          <= err_s;
            err_node     <= err_node_s;
        end
    end

endmodule

// File: tb/tb_verlet_scheduler.sv
// Scoreboard bench for verlet_scheduler: a frame planner draws per-step ack
// delays, derives the expected strobe segments and frame results, and queues
// them; a driver answers strobes with those delays (plus noise on other nodes)
// and a monitor turns observed strobes into segments and checks them.
module tb_verlet_scheduler;

    localparam int N     = 5;
    localparam int ITERS = 3;
    localparam int TO    = 8;
    localparam int NW    = $clog2(N);

    typedef struct { bit fix; int node; int hold; } seg_t;
    typedef struct { int cnt; bit err; int errn; } frm_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [N-1:0]  node_done;
    logic [N-1:0]  verlet_state;
    logic [N-1:0]  fix_state;
    logic          busy;
    logic          frame_done;
    logic [31:0]   frame_count;
    logic          err;
    logic [NW-1:0] err_node;

    verlet_scheduler #(.NODES(N), .CONSTRAINT_ITERS(ITERS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .node_done(node_done),
        .verlet_state(verlet_state), .fix_state(fix_state), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count), .err(err),
        .err_node(err_node)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg_t exp_seg[$];
    frm_t exp_frm[$];
    int   drv_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int m_count = 0;
    bit m_err   = 1'b0;
    int m_errn  = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // Reference model: a frame is N verlet steps then ITERS*N fix steps; each
    // step lasts min(delay+1, TO) cycles and a delay >= TO is a timeout.
    task automatic plan(input int kind, output int len);
        int d, r, node, hold;
        bit fx;
        len = 1;
        for (int s = 0; s < N * (1 + ITERS); s++) begin
            node = s % N;
            fx   = (s >= N);
            case (kind)
                0: d = 0;
                1: d = (!fx && node == 2) ? 4 : 0;
                2: d = (node == 3) ? 1000 : 0;
                default: begin
                    r = $urandom_range(0, 9);
                    if (r < 5)      d = 0;
                    else if (r < 8) d = $urandom_range(1, 5);
                    else            d = $urandom_range(TO - 1, TO + 3);
                end
            endcase
            hold = (d >= TO) ? TO : d + 1;
            if (d >= TO) begin
                m_err  = 1'b1;
                m_errn = node;
            end
            exp_seg.push_back('{fix: fx, node: node, hold: hold});
            drv_q.push_back(d);
            len += hold;
        end
        m_count++;
        exp_frm.push_back('{cnt: m_count, err: m_err, errn: m_errn});
    endtask

    // Runs one frame from an IDLE negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_frame(input int kind, input bit hold_start);
        int len, c;
        plan(kind, len);
        start = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (!hold_start) start = $urandom_range(0, 1) == 1;
        end while (!frame_done && c < 2000);
        if (!hold_start) start = 1'b0;
        chk("frame_length", c, len);
        @(negedge clk);
    endtask

    // Driver: acknowledges the strobed node after its planned delay; random noise on other nodes.
    initial begin
        logic [2*N-1:0] prev, full;
        logic [N-1:0]   vec, noise;
        int dd, dj;
        node_done = '0;
        prev = '0; dd = 0; dj = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                node_done = '0;
                prev = '0; dj = 0;
            end else begin
                full = {fix_state, verlet_state};
                vec  = fix_state | verlet_state;
                if (full != prev && full != '0) begin
                    dd = (drv_q.size() > 0) ? drv_q.pop_front() : 0;
                    dj = 0;
                end else if (full != '0) begin
                    dj++;
                end
                prev  = full;
                noise = N'($urandom & $urandom) & ~vec;
                node_done = noise | ((full != '0 && dj >= dd) ? vec : '0);
            end
        end
    end

    // Monitor: groups strobe cycles into segments and checks them and frame ends against the queues.
    initial begin
        logic [2*N-1:0] seg_vec, vec;
        int   seg_len, node, pend;
        bit   after_done;
        seg_t e;
        frm_t f;
        seg_vec = '0; seg_len = 0; after_done = 1'b0; pend = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                seg_vec = '0; seg_len = 0; after_done = 1'b0;
            end else begin
                vec = {fix_state, verlet_state};
                if (vec != seg_vec) begin
                    if (seg_vec != '0) begin
                        node = 0;
                        for (int i = 0; i < N; i++)
                            if (seg_vec[i] || seg_vec[N+i]) node = i;
                        if (exp_seg.size() == 0) begin
                            chk("unexpected_segment", 1, 0);
                        end else begin
                            e = exp_seg.pop_front();
                            chk("seg_phase_fix", (seg_vec[2*N-1:N] != '0), e.fix);
                            chk("seg_node", node, e.node);
                            chk("seg_hold", seg_len, e.hold);
                        end
                    end
                    if (vec != '0) chk("strobe_onehot", $countones(vec), 1);
                    seg_vec = vec;
                    seg_len = (vec != '0) ? 1 : 0;
                end else if (vec != '0) begin
                    seg_len++;
                end
                if (after_done) begin
                    chk("idle_busy", busy, 0);
                    chk("frame_done_width", frame_done, 0);
                    chk("frame_count", frame_count, pend);
                    after_done = 1'b0;
                end
                if (frame_done) begin
                    chk("done_busy", busy, 1);
                    chk("done_strobes", vec, 0);
                    if (exp_frm.size() == 0) begin
                        chk("unexpected_frame_done", 1, 0);
                    end else begin
                        f = exp_frm.pop_front();
                        chk("err", err, f.err);
                        chk("err_node", err_node, f.errn);
                        pend = f.cnt;
                        after_done = 1'b1;
                    end
                end else if (busy && vec == '0) begin
                    chk("busy_without_strobe", 1, 0);
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int c, seen;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_verlet", verlet_state, 0);
        chk("rst_fix", fix_state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_err", err, 0);
        chk("rst_err_node", err_node, 0);
        reset = 1'b1;
        @(negedge clk);

        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(0, 1'b1);
        run_frame(3, 1'b1);
        run_frame(0, 1'b0);

        // Asynchronous reset in the second fix pass while node 2 is strobed.
        plan(0, c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        c = 0;
        while (seen < 2 && c < 500) begin
            if (fix_state == 5'b00100) seen++;
            if (seen < 2) @(negedge clk);
            c++;
        end
        chk("reached_mid_fix", seen, 2);
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs",
               {verlet_state, fix_state, busy, frame_done, frame_count, err, err_node}, 0);
        exp_seg.delete();
        exp_frm.delete();
        drv_q.delete();
        m_count = 0;
        m_err   = 1'b0;
        m_errn  = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_count", frame_count, 0);

        run_frame(0, 1'b0);
        for (int k = 0; k < 25; k++) begin
            run_frame(3, $urandom_range(0, 2) == 0);
            if (start == 1'b0) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("seg_queue_drained", exp_seg.size(), 0);
        chk("frame_queue_drained", exp_frm.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
